// File: rtl/fft_pkg.sv
// Shared types, defaults and the address bit-reverse helper for the FFT unload path.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        LOAD    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_LOG2N = 3;
    localparam int BR_MAX    = 16;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    function automatic logic [BR_MAX-1:0] bitrev(
        input logic [BR_MAX-1:0] v,
        input int                n
    );
        logic [BR_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < BR_MAX; i++) begin
            if (i < n) r[i] = v[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Maps the natural-order sample count to a result-buffer address.
// FFT_BITREV_EN selects bit-reversed addressing (DIT core); otherwise identity.
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic [LOG2N-1:0] count,
    output logic [LOG2N-1:0] addr
);

`ifdef FFT_BITREV_EN
    assign addr = LOG2N'(bitrev(BR_MAX'(count), LOG2N));
`else
    assign addr = count;
`endif

endmodule

// File: rtl/fft_unload_ctrl.sv
// Unloads a completed FFT result buffer as a natural-order valid/ready stream.
// Build with FFT_BITREV_EN to read a bit-reversed (DIT) buffer.
module fft_unload_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr,
    input  logic [2*WIDTH-1:0] rd_data,
    output logic [2*WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LOG2N-1:0]   out_index,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [LOG2N-1:0] LAST = '1;

    state_t           state;
    logic [LOG2N-1:0] count;
    logic [LOG2N-1:0] cnt_inc;
    logic [LOG2N-1:0] map_in;
    logic [LOG2N-1:0] addr_nxt;

    assign cnt_inc = count + 1'b1;

    // The address is registered on entry to FETCH, so map the count FETCH will use.
    assign map_in = (state == IDLE) ? '0 : cnt_inc;

    fft_bitrev_addr #(
        .LOG2N (LOG2N)
    ) u_map (
        .count (map_in),
        .addr  (addr_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        count   <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= addr_nxt;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_index <= count;
                    out_last  <= (count == LAST);
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            count   <= cnt_inc;
                            rd_en   <= 1'b1;
                            rd_addr <= addr_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
